// File: rtl/cpu_pkg.sv
// Shared pipeline types: decoded control bundle, zero-register index and the
// ID/EX stall state encoding.
package cpu_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       use_rs1;
    logic       use_rs2;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: stalls ID for one cycle when the load in EX
// writes a register that the instruction in ID is about to read.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             stall_id
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // A load targeting XZR never produces a value, so it cannot create a hazard.
  assign ex_is_load = ex_valid && ex_mem_read && (ex_rd != REG_W'(XZR));
  assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);

  // In HOLD the bubble already sits in EX, so the hazard is resolved.
  assign stall_id = !reset && !flush && !hold && id_valid && ex_is_load
                    && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and a
// saturating stall-cycle counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  ctrl_t             id_ctrl,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              flush,
  output logic              ex_valid,
  output ctrl_t             ex_ctrl,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              stall_id,
  output logic [15:0]       stall_cnt
);

  state_e state_q;
  state_e state_d;
  logic   bubble;
  ctrl_t  ctrl_in;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .reset       (reset),
    .flush       (flush),
    .hold        (state_q == HOLD),
    .id_valid    (id_valid),
    .id_use_rs1  (id_ctrl.use_rs1),
    .id_use_rs2  (id_ctrl.use_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .stall_id    (stall_id)
  );

  assign bubble = flush || stall_id || !id_valid;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = RUN;
    ctrl_in = id_ctrl;
    if (id_rd == REG_W'(XZR)) ctrl_in.reg_write = 1'b0;
    if (state_q == RUN && stall_id) state_d = HOLD;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
    end else begin
      state_q <= state_d;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rd    <= '0;
        ex_a     <= '0;
        ex_b     <= '0;
        ex_imm   <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= ctrl_in;
        ex_rd    <= id_rd;
        ex_a     <= id_a;
        ex_b     <= id_b;
        ex_imm   <= id_imm;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              stall_cnt <= '0;
    else if (stall_id && stall_cnt != '1)   stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width of operands and immediate.
REQ-002 SHALL have parameter REG_W, default 5, register-index width; index 31 is XZR.
REQ-003 SHALL have ports clk input 1 (rising-edge clock) and reset input 1; one clock, reset asynchronous and active-high.
REQ-004 SHALL have id_valid input 1, decode stage holds a real instruction.
REQ-005 SHALL have id_ctrl input ctrl_t, decoded control bundle.
REQ-006 SHALL have id_rs1, id_rs2 input REG_W, source indices; id_rd input REG_W, destination index.
REQ-007 SHALL have id_a, id_b input DATA_W, register-file read data; id_imm input DATA_W, extended immediate (zero- or sign-extended by decode).
REQ-008 SHALL have flush input 1, branch taken in a later stage; squash ID and EX contents.
REQ-009 SHALL have ex_valid, ex_ctrl, ex_rd, ex_a, ex_b, ex_imm outputs, registered EX-stage copy of the above.
REQ-010 SHALL have stall_id output 1, hold PC and IF/ID register this cycle.
REQ-011 SHALL have stall_cnt output 16, saturating count of load-use stall cycles.

Function
REQ-012 SHALL register all ex_* outputs on rising clk; ID-to-EX latency exactly one cycle.
REQ-013 SHALL assert stall_id combinationally when ex_valid, ex_ctrl.mem_read, ex_rd != 31, and ex_rd equals id_rs1 (if id_ctrl.use_rs1) or id_rs2 (if id_ctrl.use_rs2), with id_valid high.
REQ-014 SHALL, on a stall cycle, load a bubble: ex_valid 0, ex_ctrl all-zero; ex_a/ex_b/ex_imm/ex_rd don't-care but set to zero.
REQ-015 SHALL let the stalled instruction enter EX on the following cycle, giving exactly one bubble per load-use hazard.
REQ-016 SHALL, when flush is high, load a bubble regardless of stall; flush has priority over stall and normal load.
REQ-017 SHALL deassert stall_id while flush is high.
REQ-018 SHALL load a bubble when id_valid is low.
REQ-019 SHALL force ex_ctrl.reg_write to 0 when id_rd is 31, so no write to XZR propagates.
REQ-020 SHALL pass id_imm unmodified; no re-extension or truncation.
REQ-021 SHALL increment stall_cnt by 1 per cycle stall_id is high, saturating at 16'hFFFF.
REQ-022 SHALL implement two states, RUN and HOLD: RUN->HOLD on stall_id; HOLD->RUN unconditionally next cycle; HOLD->RUN on flush.
REQ-023 SHALL, in HOLD, suppress stall_id re-assertion (bubble already in EX clears hazard).

Reset
REQ-024 SHALL, on reset asserted, immediately clear ex_valid, ex_ctrl, ex_rd, ex_a, ex_b, ex_imm, stall_cnt to zero and state to RUN.
REQ-025 SHALL hold stall_id low during reset.
REQ-026 SHALL, if reset asserts mid-stall, discard the pending instruction; first post-reset edge loads ID normally.

Structure
REQ-027 SHALL place ctrl_t (reg_write, mem_read, mem_write, mem_to_reg, alu_src, use_rs1, use_rs2, alu_op[3:0]), XZR constant 5'd31, and state enum in shared package cpu_pkg.
REQ-028 SHALL contain one sub-module, hazard_detect, producing stall_id combinationally from ID and EX fields.

Verification
REQ-029 Normal: id_valid=1, id_imm=64'h0000_0000_0000_0FFF, id_rd=3 -> next cycle ex_imm=64'hFFF, ex_rd=3, ex_valid=1, stall_id=0.
REQ-030 Load-use: EX holds LDUR rd=5; ID ADD rs1=5 -> stall_id=1 one cycle, ex_valid=0 next, ADD in EX cycle after, stall_cnt=1.
REQ-031 XZR: EX LDUR rd=31, ID rs1=31 -> stall_id=0; ID rd=31 reg_write=1 -> ex_ctrl.reg_write=0.
REQ-032 Flush+stall same cycle: hazard present and flush=1 -> stall_id=0, ex_valid=0 next, stall_cnt unchanged.
REQ-033 Reset mid-stall: assert reset while stall_id=1 -> all ex_* zero, stall_cnt=0 before next edge.
REQ-034 Saturation: preload 65534 stall cycles, apply 3 more -> stall_cnt=16'hFFFF.
